// File: rtl/pipe_rr_arbiter.sv
// pipe_rr_arbiter: round-robin arbiter that shares one fixed-latency
// delay-then-subtract pipeline among NREQ requesters. A tag shift register
// tracks the owner and subtrahend of every in-flight item, so results are
// routed back to their owners. A pause/drain handshake allows reconfiguration.
// Optional build macro ARB_LATCHK_EN adds a sticky lat_err output that flags
// a mismatch between LATENCY and the pipeline's real depth.
`timescale 1ns/1ps
module pipe_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 5,
  parameter int DW      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic [NREQ*DW-1:0]   req_sub,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 pause,
  output logic                 paused,
  output logic [DW-1:0]        pipe_data_in,
  output logic                 pipe_data_in_valid,
  output logic [DW-1:0]        pipe_subtract,
  input  logic [DW-1:0]        pipe_data_out,
  input  logic                 pipe_data_out_valid,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_data
`ifdef ARB_LATCHK_EN
  ,
  output logic                 lat_err
`endif
);

  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LAST = LATENCY - 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    PAUSED = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 grant_en;
  logic [IDW-1:0]       last_q, last_d;
  logic [NREQ-1:0]      grant;
  logic [IDW-1:0]       grant_id;
  logic                 transfer;
  logic [LATENCY-1:0]   tag_v_q;
  logic [IDW-1:0]       tag_id_q  [LATENCY];
  logic [DW-1:0]        tag_sub_q [LATENCY];
  logic                 last_v;
  logic                 rsp_fire;
  logic                 rsp_load;
  logic [NREQ-1:0]      rsp_valid_d, rsp_valid_q;
  logic [DW-1:0]        rsp_data_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM next state: drain completes once no tag is valid; dropping pause
  // always returns to RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (pause) state_d = DRAIN;
      DRAIN:   if (!pause) state_d = RUN;
               else if (tag_v_q == '0) state_d = PAUSED;
      PAUSED:  if (!pause) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM outputs: grants only in RUN and stop in the very cycle pause is seen
  always_comb begin
    grant_en = 1'b0;
    paused   = 1'b0;
    case (state_q)
      RUN:     grant_en = !pause;
      PAUSED:  paused   = 1'b1;
      default: ;
    endcase
  end

  // Round-robin search starting one past the last granted requester
  always_comb begin
    grant    = '0;
    grant_id = '0;
    transfer = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (grant_en && !transfer && req_valid[(int'(last_q) + k) % NREQ]) begin
        transfer = 1'b1;
        grant_id = IDW'((int'(last_q) + k) % NREQ);
      end
    end
    if (transfer) grant[grant_id] = 1'b1;
  end

  assign req_ready          = grant;
  assign last_d             = transfer ? grant_id : last_q;
  assign pipe_data_in_valid = transfer;
  assign pipe_data_in       = transfer ? req_data[int'(grant_id)*DW +: DW] : '0;

  // Round-robin pointer; reset value makes requester 0 the first choice
  always_ff @(posedge clk) begin
    if (rst) last_q <= IDW'(NREQ - 1);
    else     last_q <= last_d;
  end

  // Tag valid bits shift alongside the pipeline; reset discards in-flight items
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v_q <= '0;
    end else begin
      tag_v_q[0] <= transfer;
      for (int s = 1; s < LATENCY; s++) tag_v_q[s] <= tag_v_q[s-1];
    end
  end

  // Tag payload (owner id, subtrahend); only meaningful where the valid bit is set
  always_ff @(posedge clk) begin
    tag_id_q[0]  <= grant_id;
    tag_sub_q[0] <= req_sub[int'(grant_id)*DW +: DW];
    for (int s = 1; s < LATENCY; s++) begin
      tag_id_q[s]  <= tag_id_q[s-1];
      tag_sub_q[s] <= tag_sub_q[s-1];
    end
  end

  // Subtrahend is applied at the pipeline output; zero keeps idle output at 0
  assign last_v        = tag_v_q[LAST];
  assign pipe_subtract = last_v ? tag_sub_q[LAST] : '0;

  // A result is owned only if the tag also says an item is due; stale
  // pipeline strobes after a reset therefore produce no response
  assign rsp_fire = pipe_data_out_valid & last_v;
`ifdef ARB_LATCHK_EN
  assign rsp_load = rsp_fire;
`else
  assign rsp_load = pipe_data_out_valid;
`endif

  // One-hot response strobe for the owner of the emerging result
  always_comb begin
    rsp_valid_d = '0;
    if (rsp_fire) rsp_valid_d[tag_id_q[LAST]] = 1'b1;
  end

  // Registered response; data holds between results
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (rsp_load) rsp_data_q <= pipe_data_out;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef ARB_LATCHK_EN
  logic lat_err_q;

  // Sticky flag: pipeline valid and tag valid must always agree
  always_ff @(posedge clk) begin
    if (rst)                              lat_err_q <= 1'b0;
    else if (pipe_data_out_valid != last_v) lat_err_q <= 1'b1;
  end

  assign lat_err = lat_err_q;
`endif

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Testbench for pipe_rr_arbiter: a behavioural delay-then-subtract pipeline
// plus a response scoreboard (expected owner, value and arrival cycle).
`timescale 1ns/1ps
module tb_pipe_rr_arbiter;
  localparam int NREQ    = 4;
  localparam int LATENCY = 5;
  localparam int DW      = 32;
`ifdef ARB_LATCHK_EN
  localparam int G_NCYCLES = 4;
`else
  localparam int G_NCYCLES = LATENCY;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ*DW-1:0]   req_sub = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 pause = 1'b0;
  logic                 paused;
  logic [DW-1:0]        pipe_data_in;
  logic                 pipe_data_in_valid;
  logic [DW-1:0]        pipe_subtract;
  logic [DW-1:0]        pipe_data_out;
  logic                 pipe_data_out_valid;
  logic [NREQ-1:0]      rsp_valid;
  logic [DW-1:0]        rsp_data;
`ifdef ARB_LATCHK_EN
  logic                 lat_err;
`endif

  pipe_rr_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY), .DW(DW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_data            (req_data),
    .req_sub             (req_sub),
    .req_ready           (req_ready),
    .pause               (pause),
    .paused              (paused),
    .pipe_data_in        (pipe_data_in),
    .pipe_data_in_valid  (pipe_data_in_valid),
    .pipe_subtract       (pipe_subtract),
    .pipe_data_out       (pipe_data_out),
    .pipe_data_out_valid (pipe_data_out_valid),
    .rsp_valid           (rsp_valid),
    .rsp_data            (rsp_data)
`ifdef ARB_LATCHK_EN
    ,
    .lat_err             (lat_err)
`endif
  );

  always #5 clk = ~clk;

  // Pipeline model: G_NCYCLES delay, subtract applied at output, no reset
  logic [DW-1:0]        pd [G_NCYCLES];
  logic [G_NCYCLES-1:0] pv = '0;
  always @(posedge clk) begin
    pv[0] <= (pipe_data_in_valid === 1'b1);
    pd[0] <= pipe_data_in;
    for (int s = 1; s < G_NCYCLES; s++) begin
      pv[s] <= pv[s-1];
      pd[s] <= pd[s-1];
    end
  end
  assign pipe_data_out       = pd[G_NCYCLES-1] - pipe_subtract;
  assign pipe_data_out_valid = pv[G_NCYCLES-1];

  typedef struct {
    logic [NREQ-1:0] oh;
    logic [DW-1:0]   val;
    int              due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  int   last_rsp_cyc = -1;
  int   exp_last = NREQ - 1;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (rsp_valid !== '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: rsp_valid=%b rsp_data=%0d required no response (cyc %0d)", rsp_valid, rsp_data, cyc);
        end else begin
          e = sb.pop_front();
          if (rsp_valid !== e.oh || rsp_data !== e.val || cyc != e.due) begin
            errors++;
            $display("FAIL rsp_match: got valid=%b data=%0d cyc=%0d required valid=%b data=%0d cyc=%0d", rsp_valid, rsp_data, cyc, e.oh, e.val, e.due);
          end
          last_rsp_cyc = cyc;
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checks++;
        errors++;
        e = sb.pop_front();
        $display("FAIL rsp_missing: rsp_valid=0 required valid=%b data=%0d at cyc %0d", e.oh, e.val, e.due);
      end
    end
  end

  function automatic int exp_grant(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [DW-1:0] d, input logic [DW-1:0] s);
    req_data[i*DW +: DW] = d;
    req_sub[i*DW +: DW]  = s;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    req_valid = '0;
    pause     = 1'b0;
    sb.delete();
    repeat (n) next_cycle();
    rst      = 1'b0;
    exp_last = NREQ - 1;
    mon_en   = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      next_cycle();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d responses outstanding, required 0", name, sb.size());
      sb.delete();
    end
    repeat (3) next_cycle();
  endtask

  task automatic test_reset();
    do_reset(2);
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || pipe_data_in_valid !== 1'b0 || pipe_data_in !== '0) begin
      errors++;
      $display("FAIL reset_grant: req_ready=%b in_valid=%b in=%0d required 0/0/0", req_ready, pipe_data_in_valid, pipe_data_in);
    end
    checks++;
    if (rsp_valid !== '0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL reset_rsp: rsp_valid=%b rsp_data=%0d required 0/0", rsp_valid, rsp_data);
    end
    checks++;
    if (paused !== 1'b0 || pipe_subtract !== '0) begin
      errors++;
      $display("FAIL reset_misc: paused=%b subtract=%0d required 0/0", paused, pipe_subtract);
    end
`ifdef ARB_LATCHK_EN
    checks++;
    if (lat_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_laterr: lat_err=%b required 0", lat_err);
    end
`endif
    next_cycle();
  endtask

  task automatic test_single();
    do_reset(1);
    set_req(2, 32'd100, 32'd30);
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant: req_ready=%b required 0100", req_ready);
    end
    checks++;
    if (pipe_data_in_valid !== 1'b1 || pipe_data_in !== 32'd100) begin
      errors++;
      $display("FAIL single_drive: in_valid=%b in=%0d required 1/100", pipe_data_in_valid, pipe_data_in);
    end
    sb.push_back('{4'b0100, 32'd70, cyc + LATENCY + 1});
    next_cycle();
    req_valid = '0;
    wait_drain("single");
  endtask

  task automatic test_round_robin();
    int g;
    logic [NREQ-1:0] oh;
    do_reset(1);
    for (int i = 0; i < NREQ; i++) set_req(i, DW'(10 * (i + 1)), DW'(i));
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      g  = exp_grant(req_valid, exp_last);
      oh = '0;
      oh[g] = 1'b1;
      checks++;
      if (req_ready !== oh || pipe_data_in !== DW'(10 * (g + 1))) begin
        errors++;
        $display("FAIL rr_grant[%0d]: req_ready=%b in=%0d required %b/%0d", c, req_ready, pipe_data_in, oh, 10 * (g + 1));
      end
      sb.push_back('{oh, DW'(10 * (g + 1) - g), cyc + LATENCY + 1});
      exp_last = g;
      next_cycle();
    end
    req_valid = '0;
    wait_drain("rr");
  endtask

  task automatic test_single_requester();
    logic [DW-1:0] d, s;
    do_reset(1);
    req_valid = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      d = DW'($urandom);
      s = DW'($urandom);
      set_req(1, d, s);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0010 || pipe_data_in !== d) begin
        errors++;
        $display("FAIL b2b_grant[%0d]: req_ready=%b in=%0d required 0010/%0d", c, req_ready, pipe_data_in, d);
      end
      sb.push_back('{4'b0010, d - s, cyc + LATENCY + 1});
      next_cycle();
    end
    req_valid = '0;
    wait_drain("b2b");
  endtask

  task automatic test_pause_drain();
    int g, last_due, paused_cyc;
    logic [NREQ-1:0] oh;
    do_reset(1);
    for (int i = 0; i < NREQ; i++) set_req(i, DW'(200 + i), DW'(i + 1));
    req_valid = '1;
    last_due  = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      g  = exp_grant(req_valid, exp_last);
      oh = '0;
      oh[g] = 1'b1;
      checks++;
      if (req_ready !== oh) begin
        errors++;
        $display("FAIL pause_accept[%0d]: req_ready=%b required %b", c, req_ready, oh);
      end
      last_due = cyc + LATENCY + 1;
      sb.push_back('{oh, DW'(200 + g - (g + 1)), last_due});
      exp_last = g;
      next_cycle();
    end
    pause      = 1'b1;
    paused_cyc = -1;
    for (int n = 0; n < 30 && paused_cyc < 0; n++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== '0) begin
        errors++;
        $display("FAIL pause_no_grant: req_ready=%b required 0", req_ready);
      end
      if (paused === 1'b1) paused_cyc = cyc;
      else next_cycle();
    end
    checks++;
    if (paused_cyc != last_due + 1 || last_rsp_cyc != last_due) begin
      errors++;
      $display("FAIL pause_rise: paused at cyc %0d last rsp %0d required %0d/%0d", paused_cyc, last_rsp_cyc, last_due + 1, last_due);
    end
    next_cycle();
    pause = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || paused !== 1'b1) begin
      errors++;
      $display("FAIL pause_release: req_ready=%b paused=%b required 0000/1", req_ready, paused);
    end
    next_cycle();
    @(negedge clk);
    g  = exp_grant(req_valid, exp_last);
    oh = '0;
    oh[g] = 1'b1;
    checks++;
    if (req_ready !== oh || paused !== 1'b0) begin
      errors++;
      $display("FAIL pause_resume: req_ready=%b paused=%b required %b/0", req_ready, paused, oh);
    end
    sb.push_back('{oh, DW'(200 + g - (g + 1)), cyc + LATENCY + 1});
    exp_last = g;
    next_cycle();
    req_valid = '0;
    wait_drain("pause");
  endtask

  task automatic test_pause_empty();
    do_reset(1);
    repeat (LATENCY + 1) next_cycle();
    pause = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (paused !== (n == 2)) begin
        errors++;
        $display("FAIL pause_empty[%0d]: paused=%b required %b", n, paused, (n == 2));
      end
      next_cycle();
    end
    pause = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (paused !== 1'b0) begin
      errors++;
      $display("FAIL pause_empty_exit: paused=%b required 0", paused);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    for (int i = 0; i < NREQ; i++) set_req(i, DW'(500 + i), DW'(1));
    req_valid = '1;
    repeat (3) next_cycle();
    req_valid = '0;
    repeat (2) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst      = 1'b0;
    exp_last = NREQ - 1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== '0) begin
        errors++;
        $display("FAIL reset_mid_rsp[%0d]: rsp_valid=%b required 0", n, rsp_valid);
      end
      next_cycle();
    end
    req_valid = '1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_grant: req_ready=%b required 0001", req_ready);
    end
    sb.push_back('{4'b0001, DW'(499), cyc + LATENCY + 1});
    exp_last = 0;
    next_cycle();
    req_valid = '0;
    wait_drain("reset_mid");
  endtask

  task automatic test_invalid_subtract();
    do_reset(1);
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, DW'($urandom), DW'($urandom));
      @(negedge clk);
      checks++;
      if (pipe_subtract !== '0 || rsp_valid !== '0 || pipe_data_in_valid !== 1'b0 || pipe_data_in !== '0) begin
        errors++;
        $display("FAIL idle_subtract[%0d]: subtract=%0d rsp_valid=%b in_valid=%b in=%0d required all 0", n, pipe_subtract, rsp_valid, pipe_data_in_valid, pipe_data_in);
      end
      next_cycle();
    end
  endtask

`ifdef ARB_LATCHK_EN
  task automatic test_latchk();
    do_reset(1);
    set_req(0, 32'd50, 32'd5);
    req_valid = 4'b0001;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      checks++;
      if (lat_err !== (n >= 5) || rsp_valid !== '0) begin
        errors++;
        $display("FAIL latchk[%0d]: lat_err=%b rsp_valid=%b required %b/0", n, lat_err, rsp_valid, (n >= 5));
      end
      next_cycle();
      req_valid = '0;
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (lat_err !== 1'b0) begin
      errors++;
      $display("FAIL latchk_clear: lat_err=%b required 0", lat_err);
    end
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
`ifdef ARB_LATCHK_EN
    test_pause_empty();
    test_invalid_subtract();
    test_latchk();
`else
    test_single();
    test_round_robin();
    test_single_requester();
    test_pause_drain();
    test_pause_empty();
    test_reset_mid();
    test_invalid_subtract();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/pipe_rr_arbiter.md
Name: pipe_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one fixed-latency delay-then-subtract pipeline among NREQ requesters.
- The pipeline is the Delay (G_NCYCLES) + Sub hierarchy. Its result is data_out = delayed_data − subtract, and subtract is applied combinationally at the output.
- The block accepts one operand pair per cycle and tracks ownership and subtrahend of every in-flight item in a tag shift register.
- It routes each result back to its owner and supports a pause/drain handshake for reconfiguration.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LATENCY, 5, pipeline latency in cycles; must equal the Delay G_NCYCLES.
- DW, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_data  in  NREQ*DW  packed minuends; requester i at [i*DW +: DW].
- req_sub  in  NREQ*DW  packed subtrahends, same packing.
- req_ready  out  NREQ  one-hot grant, combinational.
- pause  in  1  request to stop granting and drain.
- paused  out  1  high when drained and idle.
- pipe_data_in  out  DW  to pipeline data_in.
- pipe_data_in_valid  out  1  to pipeline data_in_valid.
- pipe_subtract  out  DW  to pipeline subtract.
- pipe_data_out  in  DW  from pipeline data_out.
- pipe_data_out_valid  in  1  from pipeline data_out_valid.
- rsp_valid  out  NREQ  one-hot result strobe, registered.
- rsp_data  out  DW  result, registered.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - state = RUN.
  - RR pointer last = NREQ-1, so requester 0 has top priority.
  - Tag register cleared.
  - rsp_valid = 0, rsp_data = 0, paused = 0.
- Arbitration:
  - In RUN with pause=0, grant the first i with req_valid[i], searching from last+1 modulo NREQ.
  - req_ready is one-hot or zero; it never depends on req_ready itself.
  - A transfer occurs when req_valid[i] & req_ready[i].
  - On a transfer, last ← i; otherwise last holds.
- Pipeline drive:
  - pipe_data_in_valid = (a transfer occurs this cycle).
  - pipe_data_in = req_data of the granted requester, else 0.
- Tag shift register:
  - LATENCY stages, each holding {v, id[clog2(NREQ)], sub[DW]}.
  - Stage 0 loads {transfer, i, req_sub[i]} every cycle; entries shift one stage per cycle.
  - The last stage aligns with pipe_data_out_valid.
- Subtrahend alignment: pipe_subtract = last-stage sub when last-stage v=1, else 0. This makes the pipeline's invalid output equal 0.
- Response:
  - On clock edge where pipe_data_out_valid=1: rsp_valid ← onehot(last-stage id), rsp_data ← pipe_data_out.
  - Otherwise rsp_valid ← 0 and rsp_data holds.
  - Total latency from accept edge to rsp_valid is LATENCY+1 cycles.
  - No response backpressure; requesters must sink every strobe.
- FSM:
  - RUN: granting. pause=1 → DRAIN. Grants stop in the same cycle pause is seen.
  - DRAIN: no grants. All tag v=0 → PAUSED. pause=0 → RUN.
  - PAUSED: paused=1, no grants. pause=0 → RUN, with grants resuming the next cycle.
- Boundary conditions:
  - Back-to-back accepts every cycle are sustained, up to LATENCY in flight.
  - A single requester alone is granted every cycle.
  - pause asserted while the tag register is already empty goes DRAIN → PAUSED in two cycles.
  - Reset mid-operation discards all in-flight tags. The team's pipeline has no reset, so late pipe_data_out_valid strobes arriving after reset are ignored by the rule below.
  - pipe_data_out_valid=1 while last-stage v=0 produces no rsp_valid.
  - LATENCY wraps with no overflow condition, because occupancy ≤ LATENCY by construction.

Optional Feature:
- ARB_LATCHK_EN defined:
  - Adds output lat_err (1 bit, reset 0, sticky until rst).
  - lat_err sets when pipe_data_out_valid differs from last-stage v in any cycle, i.e. a LATENCY/G_NCYCLES mismatch.
  - When this feature is defined, responses are gated to cycles where both pipe_data_out_valid and last-stage v are high.
- Not defined: no lat_err port; behaviour exactly as in Behaviour.

Test Plan:
- Single request: req 2 presents data=100, sub=30 for one cycle → req_ready=0b0100 that cycle; 6 cycles later rsp_valid=0b0100 and rsp_data=70; all other rsp_valid bits stay 0.
- Round robin: all 4 requesters hold valid with data=10·(i+1), sub=i for 8 cycles → grant order 0,1,2,3,0,1,2,3; responses in the same order with values 10, 19, 28, 37, repeating.
- Pause drain: pause raised after 3 accepts → no further req_ready; paused rises only after the last rsp_valid; on pause=0 grants resume from the next requester after the last granted.
- Reset mid-flight: rst pulsed 2 cycles after 3 accepts, while the pipeline keeps running → rsp_valid stays 0 thereafter; next request is granted to requester 0 first.
- Invalid-output subtract: idle bench with random req_sub → pipe_subtract = 0 every cycle and rsp_valid = 0.
- ARB_LATCHK_EN with pipeline G_NCYCLES=4, LATENCY=5: one accept → lat_err=1 after 4 cycles, rsp_valid never asserts, lat_err stays 1 until rst.
